// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM address/control pins shared by the controller and the responder
interface sram_responder_if #(parameter int ADDR_W = 18);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;
  modport master (output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N);
  modport slave (input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N);
endinterface

// File: rtl/sram_responder.sv
// sram_responder: cycle-based 2^ADDR_W x 16 SRAM model with read latency, backdoor port and checkers
module sram_responder #(
  parameter int ADDR_W = 18,
  parameter int READ_LATENCY = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   sram,
  inout  wire  [15:0]       SRAM_DQ,
  input  logic              bd_en,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [15:0]       bd_wdata,
  output logic [15:0]       bd_rdata,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              protocol_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [15:0] dq_q, dq_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic err_q, err_d;
  logic [15:0] mem [2**ADDR_W];
  logic wr, rd, same, load, drive;
  assign wr = !sram.SRAM_CE_N && !sram.SRAM_WE_N;
  assign rd = !sram.SRAM_CE_N && sram.SRAM_WE_N && !sram.SRAM_OE_N;
  assign same = sram.SRAM_ADDR == addr_q;
  assign drive = state_q == DRIVE;
  // a new or changed read address always restarts the latency count from 1
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    dq_d = dq_q;
    load = 1'b0;
    if (!rd) state_d = IDLE;
    else if (state_q == IDLE || !same) begin
      addr_d = sram.SRAM_ADDR;
      cnt_d = 3'd1;
      load = LAT == 3'd1;
      state_d = load ? DRIVE : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 3'd1;
      load = cnt_d == LAT;
      state_d = load ? DRIVE : WAIT;
    end
    if (load) dq_d = mem[sram.SRAM_ADDR];
    rd_cnt_d = (load && rd_cnt_q != '1) ? rd_cnt_q + CNT_W'(1) : rd_cnt_q;
    wr_cnt_d = (wr && wr_cnt_q != '1) ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
    err_d = err_q || (wr && (!sram.SRAM_OE_N || drive));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q <= 1'b0;
      bd_rdata <= '0;
    end else begin
      state_q <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q <= err_d;
      bd_rdata <= (bd_en && !bd_we) ? mem[bd_addr] : bd_rdata;
    end
    addr_q <= addr_d;
    cnt_q <= cnt_d;
    dq_q <= dq_d;
  end
  // backdoor write is last so it overrides a same-address pin write on both lanes
  always_ff @(posedge clk) begin
    if (wr && !sram.SRAM_LB_N) mem[sram.SRAM_ADDR][7:0] <= SRAM_DQ[7:0];
    if (wr && !sram.SRAM_UB_N) mem[sram.SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
    if (bd_en && bd_we) mem[bd_addr] <= bd_wdata;
  end
  assign SRAM_DQ[15:8] = (drive && !sram.SRAM_UB_N) ? dq_q[15:8] : 8'hzz;
  assign SRAM_DQ[7:0] = (drive && !sram.SRAM_LB_N) ? dq_q[7:0] : 8'hzz;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
  assign protocol_err = err_q;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed table, hand sequences and randomized checks against a streak-based model
module tb_sram_responder;
  localparam int AW = 18, LAT = 2;
  localparam int I = 0, W = 1, R = 2, C = 3;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  sram_responder_if #(.ADDR_W(AW)) sif();
  wire [15:0] dq;
  logic tb_drv;
  logic [15:0] tb_dq;
  assign dq = tb_drv ? tb_dq : 16'hzzzz;
  pullup (dq);
  logic bd_en, bd_we;
  logic [AW-1:0] bd_addr;
  logic [15:0] bd_wdata, bdr_a, bdr_b, rdc_a, wrc_a;
  logic [1:0] rdc_b, wrc_b;
  logic err_a, err_b;
  sram_responder #(.ADDR_W(AW), .READ_LATENCY(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .sram(sif.slave), .SRAM_DQ(dq), .bd_en(bd_en), .bd_we(bd_we),
    .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bdr_a), .rd_count(rdc_a),
    .wr_count(wrc_a), .protocol_err(err_a));
  sram_responder #(.ADDR_W(AW), .READ_LATENCY(LAT), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .sram(sif.slave), .SRAM_DQ(dq), .bd_en(bd_en), .bd_we(bd_we),
    .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bdr_b), .rd_count(rdc_b),
    .wr_count(wrc_b), .protocol_err(err_b));
  int total = 0, bad = 0;
  logic [15:0] mm [int];
  int streak = 0, rd_addr = 0, rd_n = 0, wr_n = 0;
  logic err_m = 1'b0;
  logic [15:0] lat_data = 16'h0, bdr_m = 16'h0;
  typedef struct {
    bit r; int op; int a; logic [15:0] d; bit ub, lb, be, bw; int ba; logic [15:0] bwd;
    logic [15:0] e_dq; int e_rd, e_wr; bit e_err; logic [15:0] e_bdr;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(bit r, int op, int a, logic [15:0] d, bit ub, bit lb, bit be, bit bw,
                              int ba, logic [15:0] bwd, logic [15:0] e_dq, int e_rd, int e_wr,
                              bit e_err, logic [15:0] e_bdr);
    vec_t v;
    v.r = r; v.op = op; v.a = a; v.d = d; v.ub = ub; v.lb = lb; v.be = be; v.bw = bw;
    v.ba = ba; v.bwd = bwd; v.e_dq = e_dq; v.e_rd = e_rd; v.e_wr = e_wr; v.e_err = e_err;
    v.e_bdr = e_bdr;
    return v;
  endfunction
  function automatic int sat(int n, int m);
    return n > m ? m : n;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit r, input int op, input int a, input logic [15:0] d, input bit ub,
                     input bit lb, input bit be, input bit bw, input int ba, input logic [15:0] bwd);
    bit w;
    int prev;
    logic [15:0] t;
    w = op == W || op == C;
    if (w && streak >= LAT) begin ub = 1'b1; lb = 1'b1; end
    rst = r;
    sif.SRAM_ADDR = AW'(a);
    sif.SRAM_UB_N = ub;
    sif.SRAM_LB_N = lb;
    sif.SRAM_CE_N = op == I;
    sif.SRAM_WE_N = op == I ? 1'($urandom) : !w;
    sif.SRAM_OE_N = op == I ? 1'($urandom) : !(op == R || op == C);
    tb_drv = w;
    tb_dq = d;
    bd_en = be; bd_we = bw; bd_addr = AW'(ba); bd_wdata = bwd;
    @(posedge clk);
    if (r) begin
      streak = 0; rd_n = 0; wr_n = 0; err_m = 1'b0; bdr_m = 16'h0;
    end else begin
      if (w && (op == C || streak >= LAT)) err_m = 1'b1;
      if (be && !bw) bdr_m = mm[ba];
      prev = (op == R && streak > 0 && a == rd_addr) ? streak : 0;
      if (op == R) begin
        rd_addr = a;
        streak = prev < LAT ? prev + 1 : prev;
        if (prev < LAT && streak == LAT) begin lat_data = mm[a]; rd_n++; end
      end else streak = 0;
      if (w) begin
        wr_n++;
        t = mm.exists(a) ? mm[a] : 16'h0;
        if (!lb) t[7:0] = d[7:0];
        if (!ub) t[15:8] = d[15:8];
        mm[a] = t;
      end
      if (be && bw) mm[ba] = bwd;
    end
    @(negedge clk);
  endtask
  task automatic check_model();
    logic [15:0] e;
    e[15:8] = (streak >= LAT && !sif.SRAM_UB_N) ? lat_data[15:8] : 8'hff;
    e[7:0] = (streak >= LAT && !sif.SRAM_LB_N) ? lat_data[7:0] : 8'hff;
    chk("m_dq", dq, tb_drv ? tb_dq : e);
    chk("m_rd", rdc_a, sat(rd_n, 65535));
    chk("m_rd_sat", rdc_b, sat(rd_n, 3));
    chk("m_wr", wrc_a, sat(wr_n, 65535));
    chk("m_wr_sat", wrc_b, sat(wr_n, 3));
    chk("m_err", {err_b, err_a}, {err_m, err_m});
    chk("m_bdr", {bdr_b, bdr_a}, {bdr_m, bdr_m});
  endtask
  initial begin
    int a;
    cyc(1, I, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, I, 0, 0, 1, 1, 0, 0, 0, 0);
    check_model();
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 1, 1, 'h10, 'hBEEF, 'hFFFF, 0, 0, 0, 'h0000));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 1, 0, 'h10, 0, 'hFFFF, 0, 0, 0, 'hBEEF));
    tbl.push_back(mk(0, W, 'h20, 'h1234, 0, 0, 0, 0, 0, 0, 'h1234, 0, 1, 0, 'hBEEF));
    tbl.push_back(mk(0, R, 'h20, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 0, 1, 0, 'hBEEF));
    tbl.push_back(mk(0, R, 'h20, 0, 0, 0, 0, 0, 0, 0, 'h1234, 1, 1, 0, 'hBEEF));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 1, 1, 0, 'hBEEF));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 1, 1, 'h30, 'hAAAA, 'hFFFF, 1, 1, 0, 'hBEEF));
    tbl.push_back(mk(0, W, 'h30, 'h55CC, 1, 0, 0, 0, 0, 0, 'h55CC, 1, 2, 0, 'hBEEF));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 1, 0, 'h30, 0, 'hFFFF, 1, 2, 0, 'hAACC));
    tbl.push_back(mk(0, R, 'h30, 0, 0, 1, 0, 0, 0, 0, 'hFFFF, 1, 2, 0, 'hAACC));
    tbl.push_back(mk(0, R, 'h30, 0, 0, 1, 0, 0, 0, 0, 'hAAFF, 2, 2, 0, 'hAACC));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 1, 1, 'h2, 'h7777, 'hFFFF, 2, 2, 0, 'hAACC));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 1, 1, 'h1, 'h1111, 'hFFFF, 2, 2, 0, 'hAACC));
    tbl.push_back(mk(0, R, 'h1, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 2, 2, 0, 'hAACC));
    tbl.push_back(mk(0, R, 'h2, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 2, 2, 0, 'hAACC));
    tbl.push_back(mk(0, R, 'h2, 0, 0, 0, 0, 0, 0, 0, 'h7777, 3, 2, 0, 'hAACC));
    tbl.push_back(mk(0, R, 'h20, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 3, 2, 0, 'hAACC));
    tbl.push_back(mk(0, R, 'h20, 0, 0, 0, 0, 0, 0, 0, 'h1234, 4, 2, 0, 'hAACC));
    tbl.push_back(mk(0, W, 'h20, 'h0000, 1, 1, 0, 0, 0, 0, 'h0000, 4, 3, 1, 'hAACC));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 1, 0, 'h20, 0, 'hFFFF, 4, 3, 1, 'h1234));
    tbl.push_back(mk(1, I, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 0, 0, 0, 'h0000));
    tbl.push_back(mk(0, C, 'h3, 'h0F0F, 0, 0, 0, 0, 0, 0, 'h0F0F, 0, 1, 1, 'h0000));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 1, 0, 'h3, 0, 'hFFFF, 0, 1, 1, 'h0F0F));
    tbl.push_back(mk(0, R, 'h3, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 0, 1, 1, 'h0F0F));
    tbl.push_back(mk(0, R, 'h3, 0, 0, 0, 0, 0, 0, 0, 'h0F0F, 1, 1, 1, 'h0F0F));
    tbl.push_back(mk(1, R, 'h3, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 0, 0, 0, 'h0000));
    tbl.push_back(mk(0, R, 'h3, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 0, 0, 0, 'h0000));
    tbl.push_back(mk(0, I, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 0, 0, 0, 'h0000));
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].ub, tbl[i].lb, tbl[i].be, tbl[i].bw,
          tbl[i].ba, tbl[i].bwd);
      chk($sformatf("t%0d_dq", i), dq, tbl[i].e_dq);
      chk($sformatf("t%0d_rd", i), {rdc_b, rdc_a}, {2'(sat(tbl[i].e_rd, 3)), 16'(tbl[i].e_rd)});
      chk($sformatf("t%0d_wr", i), {wrc_b, wrc_a}, {2'(sat(tbl[i].e_wr, 3)), 16'(tbl[i].e_wr)});
      chk($sformatf("t%0d_err", i), {err_b, err_a}, {tbl[i].e_err, tbl[i].e_err});
      chk($sformatf("t%0d_bdr", i), bdr_a, tbl[i].e_bdr);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, R, 'h2, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, R, 'h2, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, I, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    chk("rd_four", rdc_a, 4);
    chk("rd_saturated", rdc_b, 3);
    for (int k = 0; k < 5; k++) cyc(0, W, 'h8, 16'(k), 0, 0, 0, 0, 0, 0);
    chk("wr_five", wrc_a, 5);
    chk("wr_saturated", wrc_b, 3);
    cyc(0, W, 'h5, 'h1212, 0, 0, 1, 1, 'h5, 'h3434);
    cyc(0, I, 0, 0, 0, 0, 1, 0, 'h5, 0);
    chk("bd_collision", bdr_a, 'h3434);
    cyc(0, I, 0, 0, 0, 0, 1, 1, 'h6, 'h5656);
    cyc(0, W, 'h6, 'h6565, 0, 0, 1, 0, 'h6, 0);
    chk("bd_prewrite", bdr_a, 'h5656);
    cyc(0, I, 0, 0, 0, 0, 1, 0, 'h6, 0);
    chk("bd_postwrite", bdr_a, 'h6565);
    for (int k = 0; k < 16; k++) cyc(0, I, 0, 0, 0, 0, 1, 1, k, 16'($urandom));
    check_model();
    a = 0;
    for (int n = 0; n < 600; n++) begin
      bit r, be;
      int op, sel;
      r = $urandom_range(0, 99) < 2;
      sel = $urandom_range(0, 9);
      op = sel < 2 ? I : sel < 4 ? W : sel < 9 ? R : C;
      if (r && (op == W || op == C)) op = I;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 15);
      be = !r && $urandom_range(0, 3) == 0;
      cyc(r, op, a, 16'($urandom), 1'($urandom), 1'($urandom), be, 1'($urandom),
          $urandom_range(0, 15), 16'($urandom));
      check_model();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
